// File: rtl/clk_reconfig_sequencer.sv
// Run-time clock reconfiguration sequencer for clock_subsystem.
// A new source / divider / function-mux setting is applied by gating the
// downstream ICGs, stopping the dividers, switching the selects, waiting for
// settling and then re-enabling dividers and gates in reverse order.
// Every output is a register driven from the current state, so each
// state's effect becomes visible one edge after the state is entered.
module clk_reconfig_sequencer #(
  parameter int          GATE_WAIT   = 4,
  parameter int          DIV_WAIT    = 8,
  parameter int          SETTLE_WAIT = 16,
  parameter logic [7:0]  RESET_FRAC  = 8'd4
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       cfg_req,
  output logic       cfg_ready,
  input  logic       req_clk_src_sel,
  input  logic [1:0] req_int_div_sel,
  input  logic [7:0] req_frac_div_ratio,
  input  logic       req_frac_en,
  input  logic [1:0] req_func_clk_sel,
  input  logic       dsp_en_req,
  input  logic       periph_en_req,
  output logic       clk_src_sel,
  output logic [1:0] int_div_sel,
  output logic [7:0] frac_div_ratio,
  output logic [1:0] func_clk_sel,
  output logic       div_enable,
  output logic       frac_div_enable,
  output logic       dsp_clk_en,
  output logic       periph_clk_en,
  output logic       cfg_done,
  output logic       cfg_err
);

  typedef enum logic [2:0] {
    IDLE,
    GATE_OFF,
    DIV_OFF,
    SWITCH,
    SETTLE,
    DIV_ON,
    GATE_ON
  } state_t;

  // Counter reload values: a state lasting N cycles is entered with N-1
  // and left on the edge where the counter reads zero.
  localparam logic [7:0] GATE_LD   = 8'(GATE_WAIT - 1);
  localparam logic [7:0] DIV_LD    = 8'(DIV_WAIT - 1);
  localparam logic [7:0] SETTLE_LD = 8'(SETTLE_WAIT - 1);

  state_t     state;
  logic [7:0] cnt;

  // Active configuration (what clock_subsystem is running with)
  logic       act_clk_src;
  logic [1:0] act_int_div;
  logic [7:0] act_ratio;
  logic       act_frac_en;
  logic [1:0] act_func;

  // Shadow copy of the accepted request
  logic       sh_clk_src;
  logic [1:0] sh_int_div;
  logic [7:0] sh_ratio;
  logic       sh_frac_en;
  logic [1:0] sh_func;

  logic req_take;
  logic req_bad;
  logic req_same;

  // A request is only looked at while the sequencer is idle.
  assign req_take = (state == IDLE) && cfg_req;
  // The fractional divider cannot run with a ratio below 2.
  assign req_bad  = req_frac_en && (req_frac_div_ratio < 8'd2);
  assign req_same = (req_clk_src_sel    == act_clk_src) &&
                    (req_int_div_sel    == act_int_div) &&
                    (req_frac_div_ratio == act_ratio)   &&
                    (req_frac_en        == act_frac_en) &&
                    (req_func_clk_sel   == act_func);

  // Shadow capture of the request fields; contents only matter once a
  // request has been accepted, so they carry no reset.
  always_ff @(posedge clk_in) begin
    if (req_take) begin
      sh_clk_src <= req_clk_src_sel;
      sh_int_div <= req_int_div_sel;
      sh_ratio   <= req_frac_div_ratio;
      sh_frac_en <= req_frac_en;
      sh_func    <= req_func_clk_sel;
    end
  end

  // Sequencer FSM with wait counter, active config and registered outputs.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= 8'd0;
      cfg_ready       <= 1'b1;
      act_clk_src     <= 1'b0;
      act_int_div     <= 2'd0;
      act_ratio       <= RESET_FRAC;
      act_frac_en     <= 1'b1;
      act_func        <= 2'd0;
      clk_src_sel     <= 1'b0;
      int_div_sel     <= 2'd0;
      frac_div_ratio  <= RESET_FRAC;
      func_clk_sel    <= 2'd0;
      div_enable      <= 1'b1;
      frac_div_enable <= 1'b1;
      dsp_clk_en      <= 1'b0;
      periph_clk_en   <= 1'b0;
      cfg_done        <= 1'b0;
      cfg_err         <= 1'b0;
    end else begin
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;

      // Selects always present the active config one edge later.
      clk_src_sel    <= act_clk_src;
      int_div_sel    <= act_int_div;
      frac_div_ratio <= act_ratio;
      func_clk_sel   <= act_func;

      case (state)
        IDLE: begin
          dsp_clk_en      <= dsp_en_req;
          periph_clk_en   <= periph_en_req;
          div_enable      <= 1'b1;
          frac_div_enable <= act_frac_en;
          if (req_take) begin
            if (req_bad) begin
              cfg_err <= 1'b1;
            end else if (req_same) begin
              cfg_done <= 1'b1;
            end else begin
              state     <= GATE_OFF;
              cnt       <= GATE_LD;
              cfg_ready <= 1'b0;
            end
          end
        end

        GATE_OFF: begin
          dsp_clk_en      <= 1'b0;
          periph_clk_en   <= 1'b0;
          div_enable      <= 1'b1;
          frac_div_enable <= act_frac_en;
          if (cnt == 8'd0) begin
            state <= DIV_OFF;
            cnt   <= DIV_LD;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        DIV_OFF: begin
          dsp_clk_en      <= 1'b0;
          periph_clk_en   <= 1'b0;
          div_enable      <= 1'b0;
          frac_div_enable <= 1'b0;
          if (cnt == 8'd0) begin
            state <= SWITCH;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        SWITCH: begin
          dsp_clk_en      <= 1'b0;
          periph_clk_en   <= 1'b0;
          div_enable      <= 1'b0;
          frac_div_enable <= 1'b0;
          act_clk_src     <= sh_clk_src;
          act_int_div     <= sh_int_div;
          act_ratio       <= sh_ratio;
          act_frac_en     <= sh_frac_en;
          act_func        <= sh_func;
          state           <= SETTLE;
          cnt             <= SETTLE_LD;
        end

        SETTLE: begin
          dsp_clk_en      <= 1'b0;
          periph_clk_en   <= 1'b0;
          div_enable      <= 1'b0;
          frac_div_enable <= 1'b0;
          if (cnt == 8'd0) begin
            state <= DIV_ON;
            cnt   <= DIV_LD;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        DIV_ON: begin
          dsp_clk_en      <= 1'b0;
          periph_clk_en   <= 1'b0;
          div_enable      <= 1'b1;
          frac_div_enable <= sh_frac_en;
          if (cnt == 8'd0) begin
            state <= GATE_ON;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        GATE_ON: begin
          dsp_clk_en      <= dsp_en_req;
          periph_clk_en   <= periph_en_req;
          div_enable      <= 1'b1;
          frac_div_enable <= act_frac_en;
          cfg_done        <= 1'b1;
          cfg_ready       <= 1'b1;
          state           <= IDLE;
        end

        default: begin
          state     <= IDLE;
          cfg_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_reconfig_sequencer.sv
// Testbench for clk_reconfig_sequencer: directed requests, expected
// completions queued by the stimulus and checked by an independent monitor.
module tb_clk_reconfig_sequencer;

  logic       clk_in = 1'b0;
  logic       rst_n  = 1'b0;
  logic       cfg_req = 1'b0;
  logic       cfg_ready;
  logic       req_clk_src_sel = 1'b0;
  logic [1:0] req_int_div_sel = 2'd0;
  logic [7:0] req_frac_div_ratio = 8'd0;
  logic       req_frac_en = 1'b0;
  logic [1:0] req_func_clk_sel = 2'd0;
  logic       dsp_en_req = 1'b0;
  logic       periph_en_req = 1'b0;
  logic       clk_src_sel;
  logic [1:0] int_div_sel;
  logic [7:0] frac_div_ratio;
  logic [1:0] func_clk_sel;
  logic       div_enable;
  logic       frac_div_enable;
  logic       dsp_clk_en;
  logic       periph_clk_en;
  logic       cfg_done;
  logic       cfg_err;

  clk_reconfig_sequencer dut (
    .clk_in             (clk_in),
    .rst_n              (rst_n),
    .cfg_req            (cfg_req),
    .cfg_ready          (cfg_ready),
    .req_clk_src_sel    (req_clk_src_sel),
    .req_int_div_sel    (req_int_div_sel),
    .req_frac_div_ratio (req_frac_div_ratio),
    .req_frac_en        (req_frac_en),
    .req_func_clk_sel   (req_func_clk_sel),
    .dsp_en_req         (dsp_en_req),
    .periph_en_req      (periph_en_req),
    .clk_src_sel        (clk_src_sel),
    .int_div_sel        (int_div_sel),
    .frac_div_ratio     (frac_div_ratio),
    .func_clk_sel       (func_clk_sel),
    .div_enable         (div_enable),
    .frac_div_enable    (frac_div_enable),
    .dsp_clk_en         (dsp_clk_en),
    .periph_clk_en      (periph_clk_en),
    .cfg_done           (cfg_done),
    .cfg_err            (cfg_err)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    bit         err;
    int         cyc;
    logic       src;
    logic [1:0] idiv;
    logic [7:0] ratio;
    logic [1:0] func;
    logic       fen;
    logic       dsp;
    logic       per;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   acc;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic req(input logic src, input logic [1:0] idiv, input logic [7:0] ratio,
                     input logic fen, input logic [1:0] func);
    req_clk_src_sel    = src;
    req_int_div_sel    = idiv;
    req_frac_div_ratio = ratio;
    req_frac_en        = fen;
    req_func_clk_sel   = func;
    cfg_req            = 1'b1;
    tick(1);
    cfg_req = 1'b0;
    acc     = cyc;
  endtask

  task automatic push(input bit err, input int dly, input logic src, input logic [1:0] idiv,
                      input logic [7:0] ratio, input logic [1:0] func, input logic fen,
                      input logic dsp, input logic per);
    exp_t e;
    e.err = err; e.cyc = acc + dly; e.src = src; e.idiv = idiv; e.ratio = ratio;
    e.func = func; e.fen = fen; e.dsp = dsp; e.per = per;
    sb.push_back(e);
  endtask

  // Monitor: every done/err pulse must match the oldest queued expectation.
  always @(negedge clk_in) begin
    if (rst_n && (cfg_done || cfg_err)) begin
      chk("done_err_excl", 32'(cfg_done & cfg_err), 0);
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 32'({cfg_done, cfg_err}), 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_kind_err", 32'(cfg_err), 32'(e.err));
        chk("sb_latency", 32'(cyc), 32'(e.cyc));
        chk("sb_clk_src", 32'(clk_src_sel), 32'(e.src));
        chk("sb_int_div", 32'(int_div_sel), 32'(e.idiv));
        chk("sb_ratio", 32'(frac_div_ratio), 32'(e.ratio));
        chk("sb_func", 32'(func_clk_sel), 32'(e.func));
        chk("sb_frac_en", 32'(frac_div_enable), 32'(e.fen));
        chk("sb_div_en", 32'(div_enable), 1);
        chk("sb_dsp_en", 32'(dsp_clk_en), 32'(e.dsp));
        chk("sb_per_en", 32'(periph_clk_en), 32'(e.per));
      end
    end
  end

  initial begin
    // 1: reset values and enable follow
    tick(2);
    chk("rst_ready", 32'(cfg_ready), 1);
    chk("rst_div_en", 32'(div_enable), 1);
    chk("rst_frac_en", 32'(frac_div_enable), 1);
    chk("rst_ratio", 32'(frac_div_ratio), 4);
    chk("rst_dsp_en", 32'(dsp_clk_en), 0);
    chk("rst_done", 32'(cfg_done), 0);
    rst_n = 1'b1;
    tick(1);
    dsp_en_req    = 1'b1;
    periph_en_req = 1'b1;
    chk("dsp_before_edge", 32'(dsp_clk_en), 0);
    tick(1);
    chk("dsp_follow", 32'(dsp_clk_en), 1);
    chk("per_follow", 32'(periph_clk_en), 1);

    // 2: full sequence with edge-accurate checkpoints
    req(1'b1, 2'd2, 8'd6, 1'b1, 2'd0);
    push(1'b0, 38, 1'b1, 2'd2, 8'd6, 2'd0, 1'b1, 1'b1, 1'b1);
    chk("t2_ready_low", 32'(cfg_ready), 0);
    chk("t2_dsp_e0", 32'(dsp_clk_en), 1);
    tick(1);
    chk("t2_dsp_e1", 32'(dsp_clk_en), 0);
    chk("t2_per_e1", 32'(periph_clk_en), 0);
    tick(3);
    chk("t2_div_e4", 32'(div_enable), 1);
    tick(1);
    chk("t2_div_e5", 32'(div_enable), 0);
    chk("t2_fdiv_e5", 32'(frac_div_enable), 0);
    tick(8);
    chk("t2_src_e13", 32'(clk_src_sel), 0);
    tick(1);
    chk("t2_src_e14", 32'(clk_src_sel), 1);
    chk("t2_idiv_e14", 32'(int_div_sel), 2);
    chk("t2_ratio_e14", 32'(frac_div_ratio), 6);
    tick(15);
    chk("t2_div_e29", 32'(div_enable), 0);
    tick(1);
    chk("t2_div_e30", 32'(div_enable), 1);
    chk("t2_fdiv_e30", 32'(frac_div_enable), 1);
    chk("t2_dsp_e30", 32'(dsp_clk_en), 0);
    tick(9);
    chk("t2_ready_e39", 32'(cfg_ready), 1);
    chk("t2_dsp_e39", 32'(dsp_clk_en), 1);

    // 3a: fractional ratio below 2 rejected, nothing gated
    req(1'b1, 2'd2, 8'd1, 1'b1, 2'd0);
    push(1'b1, 0, 1'b1, 2'd2, 8'd6, 2'd0, 1'b1, 1'b1, 1'b1);
    tick(1);
    chk("t3_dsp_kept", 32'(dsp_clk_en), 1);
    chk("t3_ready", 32'(cfg_ready), 1);
    chk("t3_ratio_kept", 32'(frac_div_ratio), 6);
    tick(3);

    // 3b: ratio 1 with fractional divider off is accepted
    req(1'b1, 2'd2, 8'd1, 1'b0, 2'd0);
    push(1'b0, 38, 1'b1, 2'd2, 8'd1, 2'd0, 1'b0, 1'b1, 1'b1);
    tick(1);
    chk("t3b_dsp_gated", 32'(dsp_clk_en), 0);
    tick(38);
    chk("t3b_fdiv_off", 32'(frac_div_enable), 0);

    // 4: identical config completes immediately without gating
    req(1'b1, 2'd2, 8'd1, 1'b0, 2'd0);
    push(1'b0, 0, 1'b1, 2'd2, 8'd1, 2'd0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("t4_dsp_kept", 32'(dsp_clk_en), 1);
    end
    chk("t4_ready", 32'(cfg_ready), 1);

    // 5a: second request during SETTLE is ignored
    req(1'b1, 2'd2, 8'd1, 1'b0, 2'd1);
    push(1'b0, 38, 1'b1, 2'd2, 8'd1, 2'd1, 1'b0, 1'b1, 1'b1);
    tick(19);
    req_func_clk_sel   = 2'd3;
    req_frac_div_ratio = 8'd9;
    cfg_req            = 1'b1;
    tick(1);
    cfg_req = 1'b0;
    chk("t5_ready_settle", 32'(cfg_ready), 0);
    tick(18);
    chk("t5_func_first", 32'(func_clk_sel), 1);
    chk("t5_ratio_first", 32'(frac_div_ratio), 1);
    tick(5);

    // 5b: reset during DIV_OFF discards the sequence
    req(1'b0, 2'd1, 8'd8, 1'b1, 2'd2);
    tick(6);
    chk("t5_div_off", 32'(div_enable), 0);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_src", 32'(clk_src_sel), 0);
    chk("t5_rst_idiv", 32'(int_div_sel), 0);
    chk("t5_rst_ratio", 32'(frac_div_ratio), 4);
    chk("t5_rst_func", 32'(func_clk_sel), 0);
    chk("t5_rst_div", 32'(div_enable), 1);
    chk("t5_rst_dsp", 32'(dsp_clk_en), 0);
    chk("t5_rst_ready", 32'(cfg_ready), 1);
    tick(1);
    rst_n = 1'b1;
    tick(45);
    chk("t5_post_src", 32'(clk_src_sel), 0);
    chk("t5_post_ratio", 32'(frac_div_ratio), 4);
    chk("t5_post_dsp", 32'(dsp_clk_en), 1);

    // 6: enable change mid-sequence applies the value seen at GATE_ON
    req(1'b1, 2'd0, 8'd5, 1'b1, 2'd0);
    push(1'b0, 38, 1'b1, 2'd0, 8'd5, 2'd0, 1'b1, 1'b1, 1'b0);
    tick(15);
    periph_en_req = 1'b0;
    tick(24);
    chk("t6_per_off", 32'(periph_clk_en), 0);
    chk("t6_dsp_on", 32'(dsp_clk_en), 1);

    // drain: every queued expectation must have been consumed
    for (int i = 0; i < 100 && sb.size() != 0; i++) tick(1);
    chk("sb_drain", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/clk_reconfig_sequencer.md
Name: clk_reconfig_sequencer

Overview:
Safe run-time reconfiguration controller for clock_subsystem. Requesters program a new source, divider or function-mux setting. The block then sequences the change: gate off downstream ICG enables, stop the dividers, apply the new selects, wait for settling, then re-enable in reverse order. It runs on the always-present reference clock (ext_clk at the top level) and drives the config/enable inputs of clock_subsystem that are currently tied off.

Parameters:
GATE_WAIT, 4, cycles held in GATE_OFF after ICG enables drop (≥1)
DIV_WAIT, 8, cycles held in DIV_OFF and in DIV_ON (≥1)
SETTLE_WAIT, 16, cycles held in SETTLE after selects switch (≥1)
RESET_FRAC, 8'd4, reset value of frac_div_ratio

Ports:
clk_in  input  1  reference clock, free-running
rst_n  input  1  asynchronous active-low reset
cfg_req  input  1  request, sampled only when cfg_ready=1
cfg_ready  output  1  high in IDLE only
req_clk_src_sel  input  1  requested source select
req_int_div_sel  input  2  requested integer divide select
req_frac_div_ratio  input  8  requested fractional ratio
req_frac_en  input  1  requested fractional divider enable
req_func_clk_sel  input  2  requested function-mux select
dsp_en_req  input  1  user DSP clock enable
periph_en_req  input  1  user peripheral clock enable
clk_src_sel  output  1  active source select
int_div_sel  output  2  active integer divide select
frac_div_ratio  output  8  active fractional ratio
func_clk_sel  output  2  active function-mux select
div_enable  output  1  integer divider enable
frac_div_enable  output  1  fractional divider enable
dsp_clk_en  output  1  DSP ICG enable
periph_clk_en  output  1  peripheral ICG enable
cfg_done  output  1  one-cycle pulse: request completed
cfg_err  output  1  one-cycle pulse: request rejected

Behaviour:
- One clock (clk_in); reset asynchronous, active-low. All outputs are registered.
- Reset values:
  - state=IDLE, cfg_ready=1.
  - clk_src_sel=0, int_div_sel=0, func_clk_sel=0, frac_div_ratio=RESET_FRAC.
  - div_enable=1, frac_div_enable=1.
  - dsp_clk_en=0, periph_clk_en=0, cfg_done=0, cfg_err=0.
- Wait counter: 8 bits, loaded with WAIT-1 on state entry; the state is left when the counter reads 0.
- IDLE:
  - dsp_clk_en and periph_clk_en follow dsp_en_req and periph_en_req with 1-cycle latency.
  - On cfg_req, capture all req_* into shadow registers.
    - req_frac_en=1 and req_frac_div_ratio<2: cfg_err pulses next cycle; stay IDLE; active config unchanged.
    - Shadow equal to the active config (all selects, ratio, frac enable): cfg_done pulses next cycle; stay IDLE; no gating.
    - Otherwise go to GATE_OFF.
- GATE_OFF (GATE_WAIT cycles):
  - dsp_clk_en=0 and periph_clk_en=0. They stay 0 through DIV_ON, regardless of the user requests.
- DIV_OFF (DIV_WAIT cycles):
  - div_enable=0, frac_div_enable=0.
- SWITCH (1 cycle):
  - Active selects and ratio load from shadow; visible on outputs from the first SETTLE cycle.
- SETTLE (SETTLE_WAIT cycles):
  - Dividers and gates remain off.
- DIV_ON (DIV_WAIT cycles):
  - div_enable=1; frac_div_enable=shadow frac enable.
- GATE_ON (1 cycle):
  - ICG enables load from the current dsp_en_req and periph_en_req.
  - cfg_done=1 for this cycle; next state IDLE.
- Latency: with defaults, cfg_done is asserted 38 cycles after the accepting edge (4+8+1+16+8, then GATE_ON).
- cfg_req is ignored while cfg_ready=0. There is no queue, and no error is flagged.
- cfg_done and cfg_err are never asserted together.
- Reset asserted mid-sequence: immediate return to reset values. A partially applied config is discarded.
- User enable changes during a sequence are not tracked. The value at GATE_ON is applied.

Test Plan:
1. Reset, then dsp_en_req=1 → dsp_clk_en=1 one cycle later. cfg_ready=1, div_enable=1, frac_div_ratio=4.
2. cfg_req with req_clk_src_sel=1, req_int_div_sel=2, ratio=6, frac_en=1:
   - dsp_clk_en drops on edge 1.
   - div_enable drops on edge 5.
   - clk_src_sel=1 and int_div_sel=2 from edge 14.
   - div_enable=1 on edge 30.
   - cfg_done pulse at edge 38, then cfg_ready=1.
3. cfg_req with ratio=1, frac_en=1 → cfg_err one cycle, all outputs unchanged, no gating. Ratio=1 with frac_en=0 is accepted.
4. cfg_req identical to the active config → cfg_done the next cycle; dsp_clk_en never drops.
5. Assert a second cfg_req during SETTLE → ignored, and the first config completes. Pulse rst_n low during DIV_OFF → reset values immediately, including clk_src_sel=0.
6. Toggle periph_en_req 1→0 during SETTLE → periph_clk_en stays 0 after GATE_ON.
